// File: rtl/exu_seq.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a valid/ready port,
// hands each instruction to the decoder, gates EXU writeback and tracks halts.
module exu_seq #(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = 32'h80000000,
  parameter int                  TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  output logic [31:0]         inst,
  output logic                idu_valid,
  output logic [DATA_LEN-1:0] pc,
  input  logic                ebreak,
  input  logic                exu_dest_wen,
  input  logic                exu_jump_flag,
  input  logic [DATA_LEN-1:0] exu_jump_pc,
  output logic                rf_wen,
  output logic [31:0]         instret,
  output logic                halted,
  output logic [1:0]          halt_code
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXEC,
    HALT
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic       misaligned;

  assign misaligned = exu_jump_flag && (exu_jump_pc[1:0] != 2'b00);

  // Strobes decode the registered state; gating with rst keeps them low during reset.
  assign imem_req_valid = !rst && (state == FETCH_REQ);
  assign imem_addr      = pc;
  assign idu_valid      = !rst && (state == DECODE);
  assign rf_wen         = !rst && (state == EXEC) && !ebreak && !misaligned && exu_dest_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      instret   <= '0;
      halted    <= 1'b0;
      halt_code <= 2'd0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH_REQ;

        FETCH_REQ: begin
          if (imem_req_ready) begin
            cnt   <= '0;
            state <= FETCH_WAIT;
          end
        end

        // A response arriving on the last allowed cycle still beats the timeout.
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            inst  <= imem_rsp_data;
            state <= DECODE;
          end else if (cnt == TIMEOUT_CNT) begin
            halted    <= 1'b1;
            halt_code <= 2'd2;
            state     <= HALT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DECODE: state <= EXEC;

        EXEC: begin
          if (ebreak) begin
            instret   <= instret + 32'd1;
            halted    <= 1'b1;
            halt_code <= 2'd1;
            state     <= HALT;
          end else if (misaligned) begin
            halted    <= 1'b1;
            halt_code <= 2'd3;
            state     <= HALT;
          end else begin
            instret <= instret + 32'd1;
            pc      <= exu_jump_flag ? exu_jump_pc : pc + DATA_LEN'(4);
            state   <= FETCH_REQ;
          end
        end

        HALT: state <= HALT;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_seq.sv
// Self-checking bench for exu_seq: directed vector table, hand-written corner
// sequences and randomized instruction streams against an instruction-level model.
module tb_exu_seq;

  localparam logic [31:0] RESET_PC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] inst;
  logic        idu_valid;
  logic [31:0] pc;
  logic        ebreak = 1'b0;
  logic        exu_dest_wen = 1'b0;
  logic        exu_jump_flag = 1'b0;
  logic [31:0] exu_jump_pc = '0;
  logic        rf_wen;
  logic [31:0] instret;
  logic        halted;
  logic [1:0]  halt_code;

  always #5 clk = ~clk;

  exu_seq #(.DATA_LEN(32), .RESET_PC(RESET_PC), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst(inst), .idu_valid(idu_valid),
    .pc(pc), .ebreak(ebreak), .exu_dest_wen(exu_dest_wen),
    .exu_jump_flag(exu_jump_flag), .exu_jump_pc(exu_jump_pc),
    .rf_wen(rf_wen), .instret(instret), .halted(halted), .halt_code(halt_code)
  );

  int nTests = 0;
  int nFail  = 0;

  // Instruction-level model of the architectural state.
  logic [31:0] mPc, mInstret, mInst;
  logic        mHalted;
  logic [1:0]  mCode;

  logic [31:0] lastAddr, lastInstret;
  logic        lastRfWen;

  typedef struct {
    int          rdly;
    int          wdly;
    logic        dw;
    logic        jf;
    logic [31:0] jpc;
    logic [31:0] expAddr;
    logic        expWen;
    logic [31:0] expInstret;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rsp, input logic [31:0] data,
                               input logic eb, input logic dw, input logic jf,
                               input logic [31:0] jpc);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    ebreak         = eb;
    exu_dest_wen   = dw;
    exu_jump_flag  = jf;
    exu_jump_pc    = jpc;
  endtask

  task automatic applyJunk(input logic rsp);
    applyStimulus(1'($urandom), rsp, $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom);
  endtask

  task automatic doReset(input logic lateRsp);
    @(negedge clk);
    rst = 1'b1;
    applyJunk(lateRsp);
    #1;
    checkBit("rst_req_valid", imem_req_valid, 1'b0);
    checkBit("rst_idu_valid", idu_valid, 1'b0);
    checkBit("rst_rf_wen", rf_wen, 1'b0);
    @(negedge clk);
    applyJunk(lateRsp);
    #1;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkBit("rst_halted", halted, 1'b0);
    checkOutput("rst_halt_code", {30'd0, halt_code}, 32'd0);
    checkBit("rst_req_valid2", imem_req_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyJunk(lateRsp);
    #1;
    checkBit("idle_req_valid", imem_req_valid, 1'b0);
    checkBit("idle_idu_valid", idu_valid, 1'b0);
    checkBit("idle_rf_wen", rf_wen, 1'b0);
    mPc = RESET_PC; mInstret = 0; mInst = 0; mHalted = 0; mCode = 0;
  endtask

  // One instruction: rdly cycles of refused request, wdly extra cycles before
  // the response, then decode and execute. Expects the DUT to be requesting on entry.
  task automatic runInstr(input int rdly, input int wdly, input logic [31:0] data,
                          input logic eb, input logic dw, input logic jf,
                          input logic [31:0] jpc);
    logic expWen;
    for (int i = 0; i <= rdly; i++) begin
      @(negedge clk);
      applyStimulus(i == rdly, 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom);
      #1;
      checkBit("req_valid", imem_req_valid, 1'b1);
      checkOutput("imem_addr", imem_addr, mPc);
      checkBit("idu_valid_req", idu_valid, 1'b0);
      checkBit("rf_wen_req", rf_wen, 1'b0);
      if (i == 0) lastAddr = imem_addr;
    end
    for (int i = 0; i <= wdly; i++) begin
      @(negedge clk);
      applyStimulus(1'($urandom), i == wdly, (i == wdly) ? data : $urandom,
                    1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      #1;
      checkBit("req_valid_wait", imem_req_valid, 1'b0);
      checkBit("idu_valid_wait", idu_valid, 1'b0);
      checkBit("rf_wen_wait", rf_wen, 1'b0);
      checkBit("halted_wait", halted, 1'b0);
    end
    @(negedge clk);
    applyJunk(1'($urandom));
    #1;
    checkBit("idu_valid_dec", idu_valid, 1'b1);
    checkOutput("inst_dec", inst, data);
    checkOutput("pc_dec", pc, mPc);
    checkOutput("instret_dec", instret, mInstret);
    checkBit("rf_wen_dec", rf_wen, 1'b0);
    checkBit("req_valid_dec", imem_req_valid, 1'b0);
    lastInstret = instret;
    @(negedge clk);
    applyStimulus(1'($urandom), 1'($urandom), $urandom, eb, dw, jf, jpc);
    #1;
    expWen = dw && !eb && !(jf && (jpc[1:0] != 2'b00));
    checkBit("rf_wen_exec", rf_wen, expWen);
    checkBit("idu_valid_exec", idu_valid, 1'b0);
    checkBit("req_valid_exec", imem_req_valid, 1'b0);
    lastRfWen = rf_wen;
    mInst = data;
    if (eb) begin
      mInstret = mInstret + 1; mHalted = 1; mCode = 2'd1;
    end else if (jf && (jpc[1:0] != 2'b00)) begin
      mHalted = 1; mCode = 2'd3;
    end else begin
      mInstret = mInstret + 1;
      mPc = jf ? jpc : mPc + 32'd4;
    end
  endtask

  task automatic checkHalted(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyJunk(1'($urandom));
      #1;
      checkBit("halt_req_valid", imem_req_valid, 1'b0);
      checkBit("halt_idu_valid", idu_valid, 1'b0);
      checkBit("halt_rf_wen", rf_wen, 1'b0);
      checkBit("halted", halted, mHalted);
      checkOutput("halt_code", {30'd0, halt_code}, {30'd0, mCode});
      checkOutput("halt_pc", pc, mPc);
      checkOutput("halt_instret", instret, mInstret);
      checkOutput("halt_inst", inst, mInst);
    end
  endtask

  initial begin
    logic [31:0] r;
    int sel;
    logic eb, jf;
    logic [31:0] jpc;

    vecs[0]  = '{0, 0, 1'b1, 1'b0, 32'h0,        32'h80000000, 1'b1, 32'd0};
    vecs[1]  = '{0, 0, 1'b1, 1'b0, 32'h0,        32'h80000004, 1'b1, 32'd1};
    vecs[2]  = '{0, 0, 1'b0, 1'b0, 32'h0,        32'h80000008, 1'b0, 32'd2};
    vecs[3]  = '{0, 0, 1'b1, 1'b0, 32'h0,        32'h8000000C, 1'b1, 32'd3};
    vecs[4]  = '{0, 0, 1'b1, 1'b1, 32'h80000100, 32'h80000010, 1'b1, 32'd4};
    vecs[5]  = '{0, 0, 1'b0, 1'b0, 32'h0,        32'h80000100, 1'b0, 32'd5};
    vecs[6]  = '{5, 2, 1'b1, 1'b0, 32'h0,        32'h80000104, 1'b1, 32'd6};
    vecs[7]  = '{1, 0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h80000108, 1'b1, 32'd7};
    vecs[8]  = '{0, 1, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 32'd8};
    vecs[9]  = '{0, 0, 1'b0, 1'b0, 32'h0,        32'h00000000, 1'b0, 32'd9};
    vecs[10] = '{2, 3, 1'b1, 1'b1, 32'h80000000, 32'h00000004, 1'b1, 32'd10};
    vecs[11] = '{0, 0, 1'b1, 1'b0, 32'h0,        32'h80000000, 1'b1, 32'd11};

    doReset(1'b0);
    for (int k = 0; k < 12; k++) begin
      runInstr(vecs[k].rdly, vecs[k].wdly, $urandom, 1'b0, vecs[k].dw, vecs[k].jf, vecs[k].jpc);
      checkOutput("tbl_addr", lastAddr, vecs[k].expAddr);
      checkBit("tbl_rf_wen", lastRfWen, vecs[k].expWen);
      checkOutput("tbl_instret", lastInstret, vecs[k].expInstret);
    end

    // ebreak on the third instruction retires it and stops fetching.
    doReset(1'b0);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
    runInstr(0, 0, 32'h00100073, 1'b1, 1'b1, 1'b0, 32'h0);
    checkBit("ebreak_rf_wen", lastRfWen, 1'b0);
    checkHalted(5);
    checkOutput("ebreak_instret", instret, 32'd3);
    checkOutput("ebreak_code", {30'd0, halt_code}, 32'd1);
    checkOutput("ebreak_pc", pc, 32'h80000008);

    // Reset while waiting on a response; the stale response must be ignored.
    doReset(1'b0);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("midrst_addr", imem_addr, 32'h80000004);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkBit("midrst_wait_req", imem_req_valid, 1'b0);
    doReset(1'b1);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("midrst_refetch_addr", lastAddr, 32'h80000000);
    checkOutput("midrst_instret", lastInstret, 32'd0);

    // No response ever: halt after exactly 256 cycles in the wait state.
    doReset(1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkBit("to_req_valid", imem_req_valid, 1'b1);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      applyJunk(1'b0);
      #1;
      checkBit("to_halted_early", halted, 1'b0);
      checkBit("to_req_valid_wait", imem_req_valid, 1'b0);
    end
    mHalted = 1; mCode = 2'd2;
    checkHalted(4);

    // Response on the 256th wait cycle still proceeds.
    doReset(1'b0);
    runInstr(0, 255, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("late_rsp_addr", lastAddr, 32'h80000004);

    // Misaligned redirect target halts without retiring.
    doReset(1'b0);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
    runInstr(0, 0, $urandom, 1'b0, 1'b1, 1'b1, 32'h80000102);
    checkBit("mis_rf_wen", lastRfWen, 1'b0);
    checkHalted(3);
    checkOutput("mis_pc", pc, 32'h80000004);
    checkOutput("mis_instret", instret, 32'd1);
    checkOutput("mis_code", {30'd0, halt_code}, 32'd3);

    // Randomized instruction stream.
    doReset(1'b0);
    for (int n = 0; n < 80; n++) begin
      r   = $urandom;
      sel = $urandom_range(0, 15);
      eb  = (sel == 0);
      jf  = (sel >= 1 && sel <= 6);
      jpc = {r[31:2], 2'b00};
      if (sel == 6) jpc = {r[31:2], 2'($urandom_range(1, 3))};
      runInstr($urandom_range(0, 3), $urandom_range(0, 3), $urandom, eb,
               1'($urandom), jf, jpc);
      if (mHalted) begin
        checkHalted(2);
        doReset(1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/exu_seq.md
Name: exu_seq

Overview:
- Multi-cycle instruction sequencer for the single-issue NPC core.
- Owns the PC and fetches instructions over a valid/ready instruction-memory port.
- Presents each instruction to the decoder for one cycle, then gates the EXU result into the register file.
- Applies the EXU jump redirect, counts retired instructions, and halts on ebreak, fetch timeout or misaligned target.

Parameters:
- DATA_LEN, 32, width of PC, addresses and EXU data.
- RESET_PC, 32'h80000000, PC loaded on reset.
- TIMEOUT, 255, maximum cycles spent in FETCH_WAIT before fault (8-bit counter).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  DATA_LEN  fetch address (= pc)
- imem_rsp_valid  input  1  fetch data valid
- imem_rsp_data  input  32  fetched instruction
- inst  output  32  latched instruction to IDU
- idu_valid  output  1  one-cycle pulse: inst is new
- pc  output  DATA_LEN  PC of current instruction
- ebreak  input  1  decoder flags current inst as ebreak (valid in EXEC)
- exu_dest_wen  input  1  EXU requests writeback
- exu_jump_flag  input  1  EXU redirect
- exu_jump_pc  input  DATA_LEN  redirect target
- rf_wen  output  1  register-file write strobe
- instret  output  32  retired-instruction count
- halted  output  1  core stopped
- halt_code  output  2  0 run, 1 ebreak, 2 fetch timeout, 3 misaligned target

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, inst=0, instret=0, halted=0, halt_code=0, timeout cnt=0.
- Outputs while rst=1: imem_req_valid=0, idu_valid=0, rf_wen=0.
- Reset mid-operation: abandons any in-flight fetch. A late imem_rsp_valid arriving after reset is ignored until FETCH_WAIT is re-entered.
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, HALT.
- IDLE: -> FETCH_REQ unconditionally (one cycle after reset release).
- FETCH_REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready -> FETCH_WAIT with cnt cleared; otherwise hold. imem_rsp_valid is ignored here; memory latency is at least 1 cycle.
- FETCH_WAIT:
  - On imem_rsp_valid: inst<=imem_rsp_data, -> DECODE.
  - Otherwise cnt++. When cnt==TIMEOUT and no rsp -> HALT, halt_code=2.
  - rsp and timeout in the same cycle: rsp wins.
- DECODE: idu_valid=1 for exactly this cycle; -> EXEC.
- EXEC (EXU is combinational, one cycle):
  - If ebreak: rf_wen=0, halt_code=1, -> HALT, pc unchanged, instret++.
  - Else if exu_jump_flag and exu_jump_pc[1:0]!=0: rf_wen=0, halt_code=3, -> HALT, pc unchanged, instret not incremented.
  - Else: rf_wen=exu_dest_wen, instret++, pc<=exu_jump_flag ? exu_jump_pc : pc+4, -> FETCH_REQ.
- HALT: halted=1, all strobes 0, pc/inst/instret frozen; leaves only on rst.
- rf_wen is asserted only in EXEC, so at most one write per instruction.
- pc+4 wraps modulo 2^DATA_LEN. instret wraps at 2^32-1 -> 0.
- Throughput: 4 cycles/instruction with zero-wait ready and 1-cycle response; every extra wait cycle adds 1.

Test Plan:
- Reset release, ready=1, 1-cycle rsp, stream of addi (dest_wen=1, no jump): imem_addr sequence 0x80000000, 0x80000004, 0x80000008; rf_wen pulses every 4 cycles; instret=3 after 12 cycles.
- Jump: at pc 0x80000010, exu_jump_flag=1, exu_jump_pc=0x80000100 -> next imem_addr=0x80000100; rf_wen follows exu_dest_wen.
- Backpressure: imem_req_ready low 5 cycles, then rsp delayed 3 cycles -> imem_req_valid held, addr stable; instruction retires 4+5+2 cycles after its first request (exactly 11).
- Timeout: imem_rsp_valid never asserted -> HALT with halt_code=2 after exactly 256 cycles in FETCH_WAIT; rsp arriving on the 256th cycle instead proceeds to DECODE.
- ebreak at 3rd instruction -> halted=1, halt_code=1, instret=3, rf_wen=0, no further requests. Assert rst mid-FETCH_WAIT: pc=0x80000000, instret=0, fetch restarts.
- Misaligned target exu_jump_pc=0x80000102 -> halted, halt_code=3, pc unchanged, instret not incremented.
